// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one adder_8bit among NUM_REQ requesters (stats via ADDER_SHARE_STATS_EN)
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module adder_share_arb #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cin,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_overflow,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_ovf
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, win;
  logic [7:0] a_q, a_d, b_q, b_d, sum_q, sum_d, add_sum;
  logic cin_q, cin_d, ovf_q, ovf_d, valid_q, valid_d, add_cout, found;
  int win_i;
  always_comb begin
    found = 1'b0;
    win_i = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        win_i = (int'(rr_ptr_q) + i) % NUM_REQ;
      end
    end
    win = ID_W'(win_i);
  end
  adder_8bit u_add (.a(a_q), .b(b_q), .cin(cin_q), .sum(add_sum), .cout(add_cout));
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    if (state_q == IDLE && found) begin
      state_d  = EXEC;
      id_d     = win;
      a_d      = req_a[win_i*8 +: 8];
      b_d      = req_b[win_i*8 +: 8];
      cin_d    = req_cin[win_i];
      rr_ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (state_q == EXEC) begin
      state_d = RESP;
      sum_d   = add_sum;
      ovf_d   = add_cout;
      valid_d = 1'b1;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end
  // Grant is Mealy and suppressed while reset is asserted
  assign gnt          = (state_q == IDLE && found && !rst) ? NUM_REQ'(1) << win : '0;
  assign busy         = state_q != IDLE;
  assign rsp_valid    = valid_q;
  assign rsp_id       = id_q;
  assign rsp_sum      = sum_q;
  assign rsp_overflow = ovf_q;
`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d, stat_ovf_q, stat_ovf_d;
  logic xfer;
  always_comb begin
    xfer       = valid_q && rsp_ready;
    stat_ops_d = (xfer && stat_ops_q != 16'hFFFF) ? stat_ops_q + 16'd1 : stat_ops_q;
    stat_ovf_d = (xfer && ovf_q && stat_ovf_q != 16'hFFFF) ? stat_ovf_q + 16'd1 : stat_ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end
  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`else
  assign stat_ops = '0;
  assign stat_ovf = '0;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed checks of arbitration, latency, arithmetic, backpressure and reset
module tb_adder_share_arb;
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b0;
  logic [3:0] req = '0, req_cin = '0, gnt;
  logic [31:0] req_a = '0, req_b = '0;
  logic busy, rsp_valid, rsp_overflow;
  logic [1:0] rsp_id;
  logic [7:0] rsp_sum;
  logic [15:0] stat_ops, stat_ovf;
  int checks = 0, errors = 0;
  adder_share_arb #(.NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow), .stat_ops(stat_ops), .stat_ovf(stat_ovf)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b valid=%b busy=%b required 0000/0/0", gnt, rsp_valid, busy);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_gnt: gnt=%b required 0001", gnt);
    end
    rsp_ready = 1'b1;
    tick();
    req = '0;
    tick();
    tick();
  endtask
  task automatic test_single_op();
    req_a[23:16] = 8'h7F;
    req_b[23:16] = 8'h01;
    req_cin[2] = 1'b0;
    req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL single_gnt: gnt=%b required 0100", gnt);
    end
    tick();
    req = '0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_exec: valid=%b busy=%b gnt=%b required 0/1/0000", rsp_valid, busy, gnt);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 8'h80 || rsp_overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b id=%0d sum=%h ovf=%b required 1/2/80/0", rsp_valid, rsp_id, rsp_sum, rsp_overflow);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
  endtask
  task automatic test_overflow();
    logic [15:0] exp_stat;
`ifdef ADDER_SHARE_STATS_EN
    exp_stat = 16'd1;
`else
    exp_stat = 16'd0;
`endif
    do_reset();
    req_a[7:0] = 8'hFF;
    req_b[7:0] = 8'hFF;
    req_cin[0] = 1'b1;
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'hFF || rsp_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_rsp: valid=%b id=%0d sum=%h ovf=%b required 1/0/ff/1", rsp_valid, rsp_id, rsp_sum, rsp_overflow);
    end
    tick();
    checks++;
    if (stat_ops !== exp_stat || stat_ovf !== exp_stat) begin
      errors++;
      $display("FAIL ovf_stats: ops=%0d ovf=%0d required %0d/%0d", stat_ops, stat_ovf, exp_stat, exp_stat);
    end
  endtask
  task automatic test_fairness();
    do_reset();
    rsp_ready = 1'b1;
    req = 4'b1111;
    #1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (gnt !== 4'b0001 << (i % 4)) begin
        errors++;
        $display("FAIL fair_gnt%0d: gnt=%b required %b", i, gnt, 4'b0001 << (i % 4));
      end
      for (int j = 0; j < 2; j++) begin
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
          errors++;
          $display("FAIL fair_gap%0d: gnt=%b required 0000", i, gnt);
        end
      end
      tick();
    end
  endtask
  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(8'h10 * i + 1);
      req_b[i*8 +: 8] = 8'h20;
    end
    req_cin = '0;
    rsp_ready = 1'b0;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL bp_gnt: gnt=%b required 0001", gnt);
    end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h21 || rsp_overflow !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d sum=%h ovf=%b gnt=%b busy=%b required 1/0/21/0/0000/1", i, rsp_valid, rsp_id, rsp_sum, rsp_overflow, gnt, busy);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: busy=%b valid=%b gnt=%b required 0/0/0010", busy, rsp_valid, gnt);
    end
  endtask
  task automatic test_reset_mid_op();
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst: valid=%b busy=%b gnt=%b required 0/0/0000", rsp_valid, busy, gnt);
    end
    rst = 1'b0;
    req = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_gnt: gnt=%b required 0010", gnt);
    end
    req = 4'b0110;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_rrptr: gnt=%b required 0010", gnt);
    end
    tick();
    req = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h31) begin
      errors++;
      $display("FAIL mid_rsp: valid=%b id=%0d sum=%h required 1/1/31", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_single_op();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one internally instantiated adder_8bit among NUM_REQ requesters.
- Each requester presents operands a, b and carry_in with a request line.
- The block grants one requester, registers its operands, drives the shared adder, and returns a registered sum/overflow tagged with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high with stable operands until granted.
- req_a  in  NUM_REQ*8  packed operand A; requester i uses bits [8i+7:8i].
- req_b  in  NUM_REQ*8  packed operand B; same packing as req_a.
- req_cin  in  NUM_REQ  per-requester carry_in.
- gnt  out  NUM_REQ  one-hot grant, one-cycle pulse; operands are captured at the clock edge ending that cycle.
- busy  out  1  high whenever the state is not IDLE.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready; transfer occurs when rsp_valid && rsp_ready.
- rsp_id  out  ID_W  index of the granted requester.
- rsp_sum  out  8  registered adder sum.
- rsp_overflow  out  1  registered adder overflow (carry out).
- stat_ops  out  16  completed-operation count (see Optional Feature).
- stat_ovf  out  16  overflow-event count (see Optional Feature).

Behaviour:
- One clock domain. rst is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset values: state=IDLE, rr_ptr=0, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_overflow=0, operand regs=0, stat_ops=0, stat_ovf=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req bit is high, gnt is asserted combinationally (Mealy) for the winner.
  - Winner = first set req bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - At the edge: latch the winner's a, b, cin and ID; set rr_ptr = (winner+1) mod NUM_REQ; go to EXEC.
  - If no req bit is high: gnt=0, remain in IDLE.
- EXEC:
  - Adder inputs come only from the operand registers.
  - At the edge: capture sum and overflow into rsp_sum/rsp_overflow; set rsp_valid=1; go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_sum and rsp_overflow are held stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid clears at the edge; go to IDLE.
- Latency: gnt in cycle k, rsp_valid high from cycle k+2. Minimum spacing between grants is 3 cycles (zero-wait consumer).
- gnt is never asserted outside IDLE. Requests arriving during EXEC/RESP wait; none are lost while req stays high.
- A req deasserted before grant is not serviced; no state is affected.
- The granted requester may re-request immediately. It is granted again only if it is first from rr_ptr, so a requester set {0,1} always alternates 0,1,0,1.
- Single requester: granted every IDLE visit regardless of rr_ptr.
- Arithmetic: {rsp_overflow, rsp_sum} = a + b + cin, computed at 9 bits. Example: 0xFF + 0x00 + 1 → sum=0x00, overflow=1.
- Reset mid-operation (EXEC or RESP): the pending response is discarded, rsp_valid drops the cycle after the rst edge, and the FSM returns to IDLE with rr_ptr=0.
- rst has priority over all other events.

Optional Feature:
- Macro: ADDER_SHARE_STATS_EN.
- Defined:
  - stat_ops increments on each response transfer (rsp_valid && rsp_ready).
  - stat_ovf increments on each transfer with rsp_overflow=1.
  - Both counters saturate at 0xFFFF and clear on rst.
- Undefined: stat_ops and stat_ovf remain as ports, tied to 0, with no counter logic.

Test Plan:
- Reset check: assert rst for 2 cycles with req=4'b1111 → gnt=0, rsp_valid=0, busy=0 throughout reset; first grant after release is gnt=4'b0001.
- Single op, requester 2: a=0x7F, b=0x01, cin=0, rsp_ready=1 → gnt=4'b0100 in cycle k; rsp_valid=1 in cycle k+2 with rsp_id=2, rsp_sum=0x80, rsp_overflow=0.
- Overflow boundary, requester 0: a=0xFF, b=0xFF, cin=1 → rsp_sum=0xFF, rsp_overflow=1; with ADDER_SHARE_STATS_EN defined, stat_ops=1 and stat_ovf=1.
- Fairness: req=4'b1111 held for 12 grants, rsp_ready=1 → grant order 0,1,2,3,0,1,2,3,0,1,2,3 with grants exactly 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → response fields stable, gnt=0, busy=1 throughout; one cycle after rsp_ready=1, state is IDLE and the next pending request is granted.
- Reset mid-op: assert rst during EXEC → rsp_valid never rises for that op; after release with req=4'b0010, gnt=4'b0010 and rr_ptr restarts from 0.
